branch_redirect_unit: RTL and testbench

Parametrised, registered successor to the execute-stage irregular-PC generator. Resolves the actual next PC of every control-transfer instruction (conditional branch, JAL, JALR) and compares it with the PC fetch predicted. On a mismatch it raises a one-entry redirect toward fetch, held until fetch accepts it, and it keeps saturating branch and mispredict counters. Sits between the execute stage and the fetch PC mux.

---
 rtl/branch_redirect_unit.sv | 82 ++++++++
 tb/tb_branch_redirect_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_unit.sv
// Execute-stage control-transfer resolver. It compares the resolved next PC with the
// fetch prediction and holds a one-entry redirect toward fetch until fetch accepts it.
module branch_redirect_unit #(
  parameter int XLEN       = 32,
  parameter int INST_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [1:0]       ex_kind,
  input  logic [XLEN-1:0]  ex_op1,
  input  logic [XLEN-1:0]  ex_op2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_pred_pc,
  input  logic             flush,
  input  logic             redir_ready,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  output logic             ex_stall,
  output logic [XLEN-1:0]  last_target,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] sum, target;
  logic            is_cf, mispredict, accept;

  always_comb begin
    sum    = ex_op1 + ex_op2;
    target = '0;
    case (ex_kind)
      2'b01:   target = ex_taken ? sum : ex_pc + XLEN'(INST_BYTES);
      2'b10:   target = sum;
      2'b11:   target = {sum[XLEN-1:1], 1'b0};
      default: target = '0;
    endcase
  end

  assign is_cf      = (ex_kind != 2'b00);
  assign mispredict = is_cf && (target != ex_pred_pc);
  assign accept     = ex_valid & ~ex_stall & ~flush;

  assign redir_valid = (state == PENDING);
  assign ex_stall    = (state == PENDING);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && mispredict)    state_nxt = PENDING;
      PENDING: if (flush || redir_ready)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // accept is already false while PENDING, so redir_pc stays frozen during the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_pc    <= '0;
      last_target <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (accept && is_cf) begin
      last_target <= target;
      if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict) begin
        redir_pc <= target;
        if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: a full-width and a CNT_W=2 instance share
// the stimulus and are checked every cycle against a next-PC model plus literal pins.
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [1:0]  ex_kind = 2'b00;
  logic [31:0] ex_op1 = '0, ex_op2 = '0, ex_pc = '0, ex_pred_pc = '0;
  logic        ex_taken = 1'b0;
  logic        flush = 1'b0;
  logic        redir_ready = 1'b0;

  logic        redir_valid, ex_stall, s_redir_valid, s_ex_stall;
  logic [31:0] redir_pc, last_target, s_redir_pc, s_last_target;
  logic [15:0] branch_cnt, mispred_cnt;
  logic [1:0]  s_branch_cnt, s_mispred_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_redirect_unit #(.XLEN(32), .INST_BYTES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_pred_pc(ex_pred_pc),
    .flush(flush), .redir_ready(redir_ready), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .ex_stall(ex_stall), .last_target(last_target),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt));

  branch_redirect_unit #(.XLEN(32), .INST_BYTES(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_op1(ex_op1),
    .ex_op2(ex_op2), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_pred_pc(ex_pred_pc),
    .flush(flush), .redir_ready(redir_ready), .redir_valid(s_redir_valid),
    .redir_pc(s_redir_pc), .ex_stall(s_ex_stall), .last_target(s_last_target),
    .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: unbounded event counts; the saturation limit is applied only when comparing.
  bit          m_pend;
  logic [31:0] m_rpc, m_lt;
  longint      m_bc, m_mc;

  function automatic logic [31:0] resolve(input logic [1:0] k, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] pc, input logic tk);
    logic [31:0] s;
    s = a + b;
    if (k == 2'b01) return tk ? s : pc + 32'd4;
    if (k == 2'b10) return s;
    if (k == 2'b11) return s & ~32'd1;
    return 32'd0;
  endfunction

  function automatic longint sat(input longint v, input longint lim);
    return (v > lim) ? lim : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [31:0] t;
    if (rst) begin
      m_pend = 0; m_rpc = '0; m_lt = '0; m_bc = 0; m_mc = 0;
    end else if (flush) begin
      m_pend = 0;
    end else if (m_pend) begin
      if (redir_ready) m_pend = 0;
    end else if (ex_valid && ex_kind != 2'b00) begin
      t = resolve(ex_kind, ex_op1, ex_op2, ex_pc, ex_taken);
      m_lt = t;
      m_bc++;
      if (t != ex_pred_pc) begin
        m_mc++; m_pend = 1; m_rpc = t;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("redir_valid", 64'(redir_valid), 64'(m_pend));
      chk("ex_stall", 64'(ex_stall), 64'(m_pend));
      if (m_pend) chk("redir_pc", 64'(redir_pc), 64'(m_rpc));
      chk("last_target", 64'(last_target), 64'(m_lt));
      chk("branch_cnt", 64'(branch_cnt), 64'(sat(m_bc, 65535)));
      chk("mispred_cnt", 64'(mispred_cnt), 64'(sat(m_mc, 65535)));
      chk("s_redir_valid", 64'(s_redir_valid), 64'(m_pend));
      if (m_pend) chk("s_redir_pc", 64'(s_redir_pc), 64'(m_rpc));
      chk("s_branch_cnt", 64'(s_branch_cnt), 64'(sat(m_bc, 3)));
      chk("s_mispred_cnt", 64'(s_mispred_cnt), 64'(sat(m_mc, 3)));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] pc, input logic tk, input logic [31:0] pred);
    ex_valid = 1'b1; ex_kind = k; ex_op1 = a; ex_op2 = b; ex_pc = pc;
    ex_taken = tk; ex_pred_pc = pred;
    step();
    ex_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset redir_valid", 64'(redir_valid), 64'd0);
    chk("reset redir_pc", 64'(redir_pc), 64'd0);
    chk("reset branch_cnt", 64'(branch_cnt), 64'd0);
    step();

    // Correctly predicted taken branch, then another back-to-back
    issue(2'b01, 32'h100, 32'h20, 32'h100, 1'b1, 32'h120);
    chk("pin1 branch_cnt", 64'(branch_cnt), 64'd1);
    chk("pin1 mispred_cnt", 64'(mispred_cnt), 64'd0);
    chk("pin1 last_target", 64'(last_target), 64'h120);
    chk("pin1 redir_valid", 64'(redir_valid), 64'd0);

    // Same branch mispredicted; redirect held for 3 cycles while execute is stalled
    issue(2'b01, 32'h100, 32'h20, 32'h100, 1'b1, 32'h104);
    chk("pin2 redir_valid", 64'(redir_valid), 64'd1);
    chk("pin2 redir_pc", 64'(redir_pc), 64'h120);
    chk("pin2 ex_stall", 64'(ex_stall), 64'd1);
    ex_valid = 1'b1; ex_kind = 2'b10; ex_op1 = 32'h500; ex_op2 = '0; ex_pred_pc = '0;
    repeat (3) step();
    chk("pin2 held redir_pc", 64'(redir_pc), 64'h120);
    ex_valid = 1'b0; redir_ready = 1'b1;
    step();
    redir_ready = 1'b0;
    chk("pin2 released", 64'(redir_valid), 64'd0);
    chk("pin2 mispred_cnt", 64'(mispred_cnt), 64'd1);
    chk("pin2 branch_cnt", 64'(branch_cnt), 64'd2);

    // JALR clears bit 0
    issue(2'b11, 32'h2001, 32'h4, 32'h300, 1'b0, 32'h0);
    chk("pin3 jalr redir_pc", 64'(redir_pc), 64'h2004);
    redir_ready = 1'b1; step(); redir_ready = 1'b0;

    // Not-taken branch at top of address space wraps to 0
    issue(2'b01, 32'h0, 32'h40, 32'hFFFF_FFFC, 1'b0, 32'h0);
    chk("pin4 wrap redir_valid", 64'(redir_valid), 64'd0);
    chk("pin4 wrap last_target", 64'(last_target), 64'd0);

    // kind 00 changes nothing
    issue(2'b00, 32'h10, 32'h10, 32'h10, 1'b0, 32'h5);
    chk("pin5 none branch_cnt", 64'(branch_cnt), 64'd4);

    // Mispredict, then flush together with redir_ready and a new mispredicting instruction
    issue(2'b10, 32'h400, 32'h10, 32'h400, 1'b0, 32'h0);
    chk("pin6 pending", 64'(redir_valid), 64'd1);
    flush = 1'b1; redir_ready = 1'b1;
    ex_valid = 1'b1; ex_kind = 2'b01; ex_op1 = 32'h800; ex_op2 = 32'h8; ex_taken = 1'b1;
    ex_pred_pc = 32'h0;
    step();
    flush = 1'b0; redir_ready = 1'b0; ex_valid = 1'b0;
    chk("pin6 flushed", 64'(redir_valid), 64'd0);
    chk("pin6 branch_cnt", 64'(branch_cnt), 64'd5);
    chk("pin6 mispred_cnt", 64'(mispred_cnt), 64'd3);
    chk("pin6 last_target", 64'(last_target), 64'h410);

    // Five acknowledged mispredicts saturate the narrow counters
    for (int i = 0; i < 5; i++) begin
      issue(2'b01, 32'h1000 + 32'(i * 16), 32'h8, 32'h1000, 1'b1, 32'h0);
      redir_ready = 1'b1; step(); redir_ready = 1'b0;
    end
    chk("pin7 s_mispred_cnt", 64'(s_mispred_cnt), 64'd3);
    chk("pin7 s_branch_cnt", 64'(s_branch_cnt), 64'd3);
    chk("pin7 mispred_cnt", 64'(mispred_cnt), 64'd8);
    chk("pin7 branch_cnt", 64'(branch_cnt), 64'd10);

    // Asynchronous reset while PENDING
    issue(2'b10, 32'h700, 32'h4, 32'h700, 1'b0, 32'h0);
    chk("pin8 pending", 64'(redir_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("pin8 rst redir_valid", 64'(redir_valid), 64'd0);
    chk("pin8 rst ex_stall", 64'(ex_stall), 64'd0);
    chk("pin8 rst branch_cnt", 64'(branch_cnt), 64'd0);
    chk("pin8 rst mispred_cnt", 64'(mispred_cnt), 64'd0);
    chk("pin8 rst last_target", 64'(last_target), 64'd0);
    chk("pin8 rst s_branch_cnt", 64'(s_branch_cnt), 64'd0);
    step();
    rst = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
